// File: rtl/tick_stopwatch_pkg.sv
// tick_stopwatch_pkg: state encoding, BCD field limits and a decimal-to-BCD helper
// shared by the stopwatch top and its digit-pair counters.
`default_nettype none

package tick_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int HUND_LIMIT = 99;
  localparam int SEC_LIMIT  = 59;

  // Elaboration-time conversion of a decimal limit (0..99) to two BCD digits.
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    w_tens = 4'(v / 10);
    w_ones = 4'(v % 10);
    return {w_tens, w_ones};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_stopwatch_bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD counter 00..LIMIT with synchronous clear and a
// same-cycle carry out so cascaded pairs ripple on a single edge.
`default_nettype none

module bcd_digit_pair
  import tick_stopwatch_pkg::*;
#(
  parameter int LIMIT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  localparam logic [7:0] LIMIT_BCD = to_bcd8(LIMIT);

  logic [7:0] r_value;
  logic [7:0] w_next;

  assign carry = inc && (r_value == LIMIT_BCD);
  assign value = r_value;

  always_comb begin
    w_next = r_value;
    if (r_value[3:0] == 4'd9) begin
      w_next = {r_value[7:4] + 4'd1, 4'd0};
    end else begin
      w_next = {r_value[7:4], r_value[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 8'h00;
    end else if (clr) begin
      r_value <= 8'h00;
    end else if (inc) begin
      r_value <= carry ? 8'h00 : w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_stopwatch.sv
// tick_stopwatch: BCD MM:SS.hh stopwatch with run/pause/clear commands.
// Optional lap-freeze display is compiled in with `define STOPWATCH_LAP_EN.
`default_nettype none

module tick_stopwatch
  import tick_stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       START_STOP,
  input  logic       CLEAR,
  input  logic       LAP,
  output logic [7:0] HUND_BCD,
  output logic [7:0] SEC_BCD,
  output logic [7:0] MIN_BCD,
  output logic       RUNNING,
  output logic       ROLLOVER
);

  state_t     r_state;
  logic       r_running;
  logic       r_rollover;
  logic       w_tick_en;
  logic       w_hund_carry;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic [7:0] w_hund;
  logic [7:0] w_sec;
  logic [7:0] w_min;

  // Counting follows the pre-edge state, so a PAUSE->RUN command never counts
  // its own tick while a RUN->PAUSE command does.
  assign w_tick_en = TICK && !CLEAR && ((r_state == ST_RUN) || (r_state == ST_LAP));

  bcd_digit_pair #(.LIMIT(HUND_LIMIT)) u_hund (
    .clk   (CLOCK),
    .rst_n (RESET),
    .inc   (w_tick_en),
    .clr   (CLEAR),
    .value (w_hund),
    .carry (w_hund_carry)
  );

  bcd_digit_pair #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk   (CLOCK),
    .rst_n (RESET),
    .inc   (w_hund_carry),
    .clr   (CLEAR),
    .value (w_sec),
    .carry (w_sec_carry)
  );

  bcd_digit_pair #(.LIMIT(MAX_MIN)) u_min (
    .clk   (CLOCK),
    .rst_n (RESET),
    .inc   (w_sec_carry),
    .clr   (CLEAR),
    .value (w_min),
    .carry (w_min_carry)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else if (CLEAR) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else if (START_STOP) begin
      case (r_state)
        ST_RUN, ST_LAP: begin
          r_state   <= ST_PAUSE;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
      endcase
`ifdef STOPWATCH_LAP_EN
    end else if (LAP) begin
      if (r_state == ST_RUN) begin
        r_state <= ST_LAP;
      end else if (r_state == ST_LAP) begin
        r_state <= ST_RUN;
      end
`endif
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_min_carry;
    end
  end

  assign RUNNING  = r_running;
  assign ROLLOVER = r_rollover;

`ifdef STOPWATCH_LAP_EN
  logic [7:0] r_snap_hund;
  logic [7:0] r_snap_sec;
  logic [7:0] r_snap_min;

  // Snapshot holds what was on display just before entering LAP.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_snap_hund <= 8'h00;
      r_snap_sec  <= 8'h00;
      r_snap_min  <= 8'h00;
    end else if (!CLEAR && !START_STOP && LAP && (r_state == ST_RUN)) begin
      r_snap_hund <= w_hund;
      r_snap_sec  <= w_sec;
      r_snap_min  <= w_min;
    end
  end

  assign HUND_BCD = (r_state == ST_LAP) ? r_snap_hund : w_hund;
  assign SEC_BCD  = (r_state == ST_LAP) ? r_snap_sec  : w_sec;
  assign MIN_BCD  = (r_state == ST_LAP) ? r_snap_min  : w_min;
`else
  logic w_unused_lap;
  assign w_unused_lap = LAP;

  assign HUND_BCD = w_hund;
  assign SEC_BCD  = w_sec;
  assign MIN_BCD  = w_min;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_stopwatch.sv
// tb_tick_stopwatch: drives two stopwatches (MAX_MIN 59 and 2) in lockstep and
// compares them every checked cycle against a total-hundredths reference model.
`default_nettype none

module tb_tick_stopwatch;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  logic TICK = 1'b0;
  logic START_STOP = 1'b0;
  logic CLEAR = 1'b0;
  logic LAP = 1'b0;

  logic [7:0] hund0, sec0, min0, hund1, sec1, min1;
  logic       run0, roll0, run1, roll1;
  logic [25:0] obs [2];

  assign obs[0] = {hund0, sec0, min0, run0, roll0};
  assign obs[1] = {hund1, sec1, min1, run1, roll1};

  always #5 CLOCK = ~CLOCK;

  tick_stopwatch #(.MAX_MIN(59)) u_dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .LAP(LAP), .HUND_BCD(hund0), .SEC_BCD(sec0),
    .MIN_BCD(min0), .RUNNING(run0), .ROLLOVER(roll0)
  );

  tick_stopwatch #(.MAX_MIN(2)) u_dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .LAP(LAP), .HUND_BCD(hund1), .SEC_BCD(sec1),
    .MIN_BCD(min1), .RUNNING(run1), .ROLLOVER(roll1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: elapsed time as a plain count of hundredths.
  int m_cnt [2];
  int m_snap [2];
  int m_st [2];
  bit m_roll [2];
  int m_lim [2] = '{60 * 6000, 3 * 6000};

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [25:0] exp_vec(input int i);
    int  d;
    logic r;
    d = (m_st[i] == M_LAP) ? m_snap[i] : m_cnt[i];
    r = (m_st[i] == M_RUN) || (m_st[i] == M_LAP);
    return {bcd2(d % 100), bcd2((d / 100) % 60), bcd2(d / 6000), r, m_roll[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_snap[i] = 0; m_st[i] = M_IDLE; m_roll[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit t, input bit ss, input bit clr, input bit lap);
    for (int i = 0; i < 2; i++) begin
      int pre;
      int old;
      pre = m_st[i];
      old = m_cnt[i];
      m_roll[i] = 1'b0;
      if (clr) begin
        m_cnt[i] = 0;
        m_st[i]  = M_IDLE;
      end else begin
        if (t && (pre == M_RUN || pre == M_LAP)) begin
          m_cnt[i]++;
          if (m_cnt[i] == m_lim[i]) begin
            m_cnt[i]  = 0;
            m_roll[i] = 1'b1;
          end
        end
        if (ss) begin
          m_st[i] = (pre == M_RUN || pre == M_LAP) ? M_PAUSE : M_RUN;
        end else if (lap && LAP_EN) begin
          if (pre == M_RUN) begin
            m_st[i]   = M_LAP;
            m_snap[i] = old;
          end else if (pre == M_LAP) begin
            m_st[i] = M_RUN;
          end
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cycle(input bit t, input bit ss, input bit clr, input bit lap);
    TICK = t; START_STOP = ss; CLEAR = clr; LAP = lap;
    @(posedge CLOCK);
    model_step(t, ss, clr, lap);
    @(negedge CLOCK);
    TICK = 1'b0; START_STOP = 1'b0; CLEAR = 1'b0; LAP = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    model_reset();
    repeat (3) @(negedge CLOCK);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== 26'd0) begin
        n_err++;
        $display("FAIL reset dut%0d: got %h want %h", i, obs[i], 26'd0);
      end
    end
    RESET = 1'b1;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== exp_vec(i)) begin
        n_err++;
        $display("FAIL reset_release dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_run_150();
    cycle(0, 1, 0, 0);
    repeat (150) cycle(1, 0, 0, 0);
    n_vec++;
    if ({hund0, sec0, min0, run0} !== {8'h50, 8'h01, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL run_150: got %h %h %h run=%b want 50 01 00 run=1", hund0, sec0, min0, run0);
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== exp_vec(i)) begin
        n_err++;
        $display("FAIL run_150_model dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_minute_carry();
    repeat (5849) cycle(1, 0, 0, 0);
    n_vec++;
    if ({min0, sec0, hund0} !== {8'h00, 8'h59, 8'h99}) begin
      n_err++;
      $display("FAIL at_0059_99: got %h:%h.%h want 00:59.99", min0, sec0, hund0);
    end
    cycle(1, 0, 0, 0);
    n_vec++;
    if ({min0, sec0, hund0, roll0} !== {8'h01, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL minute_carry: got %h:%h.%h roll=%b want 01:00.00 roll=0", min0, sec0, hund0, roll0);
    end
  endtask

  task automatic test_wrap();
    repeat (11999) cycle(1, 0, 0, 0);
    n_vec++;
    if ({min1, sec1, hund1, roll1} !== {8'h02, 8'h59, 8'h99, 1'b0}) begin
      n_err++;
      $display("FAIL at_0259_99: got %h:%h.%h roll=%b want 02:59.99 roll=0", min1, sec1, hund1, roll1);
    end
    cycle(1, 0, 0, 0);
    n_vec++;
    if ({min1, sec1, hund1, roll1, roll0} !== {8'h00, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL wrap: got %h:%h.%h roll1=%b roll0=%b want 00:00.00 roll1=1 roll0=0",
               min1, sec1, hund1, roll1, roll0);
    end
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== exp_vec(i)) begin
        n_err++;
        $display("FAIL wrap_after dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_pause();
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (7) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    n_vec++;
    if ({hund0, run0} !== {8'h08, 1'b0}) begin
      n_err++;
      $display("FAIL pause_counts_tick: got hund=%h run=%b want hund=08 run=0", hund0, run0);
    end
    repeat (5) cycle(1, 0, 0, 0);
    n_vec++;
    if ({min0, sec0, hund0, run0} !== {8'h00, 8'h00, 8'h08, 1'b0}) begin
      n_err++;
      $display("FAIL paused_hold: got %h:%h.%h run=%b want 00:00.08 run=0", min0, sec0, hund0, run0);
    end
    cycle(1, 1, 0, 0);
    n_vec++;
    if ({hund0, run0} !== {8'h08, 1'b1}) begin
      n_err++;
      $display("FAIL resume_drops_tick: got hund=%h run=%b want hund=08 run=1", hund0, run0);
    end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== exp_vec(i)) begin
        n_err++;
        $display("FAIL pause_model dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_lap();
    logic [7:0] want_sec;
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (300) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 200; k++) begin
      cycle(1, 0, 0, 0);
      if (k % 50 == 49) begin
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (obs[i] !== exp_vec(i)) begin
            n_err++;
            $display("FAIL lap_hold dut%0d k=%0d: got %h want %h", i, k, obs[i], exp_vec(i));
          end
        end
      end
    end
    want_sec = LAP_EN ? 8'h03 : 8'h05;
    n_vec++;
    if ({min0, sec0, hund0, run0} !== {8'h00, want_sec, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL lap_display: got %h:%h.%h run=%b want 00:%h.00 run=1", min0, sec0, hund0, run0, want_sec);
    end
    cycle(0, 0, 0, 1);
    n_vec++;
    if ({min0, sec0, hund0, run0} !== {8'h00, 8'h05, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL lap_release: got %h:%h.%h run=%b want 00:05.00 run=1", min0, sec0, hund0, run0);
    end
  endtask

  task automatic test_clear_combo();
    repeat (37) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    n_vec++;
    if (obs[0] !== 26'd0) begin
      n_err++;
      $display("FAIL clear_combo: got %h want %h", obs[0], 26'd0);
    end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== exp_vec(i)) begin
        n_err++;
        $display("FAIL clear_idle dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      bit t, ss, clr, lap;
      t   = ($urandom_range(0, 3) != 0);
      ss  = ($urandom_range(0, 40) == 0);
      clr = ($urandom_range(0, 300) == 0);
      lap = ($urandom_range(0, 25) == 0);
      cycle(t, ss, clr, lap);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs[i] !== exp_vec(i)) begin
          n_err++;
          $display("FAIL random dut%0d k=%0d: got %h want %h", i, k, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (123) cycle(1, 0, 0, 0);
    #2;
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== 26'd0) begin
        n_err++;
        $display("FAIL async_reset dut%0d: got %h want %h", i, obs[i], 26'd0);
      end
    end
    model_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs[i] !== exp_vec(i)) begin
        n_err++;
        $display("FAIL after_reset dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLOCK);
    test_reset();
    test_run_150();
    test_minute_carry();
    test_wrap();
    test_pause();
    test_lap();
    test_clear_combo();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
